io_bus_arbiter: RTL and testbench

//  Shares the single IO-port bus (io_addr/io_en/io_we/io_data_write/io_data_read) among NREQ masters
//  (core load/store unit, debug/testbench master, ...). Round-robin arbitration, one transaction in

---
 rtl/io_bus_arbiter_pkg.sv | 11 +
 rtl/io_bus_arbiter_rr_arbiter.sv | 20 ++
 rtl/io_bus_arbiter.sv | 90 +++++++++
 tb/tb_io_bus_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// io_bus_arbiter_pkg: shared widths and FSM encoding for the IO bus arbiter
package io_bus_arbiter_pkg;
    localparam int IO_ADDR_W = 8;
    localparam int IO_DATA_W = 32;
    localparam int WAIT_W    = 3;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;
endpackage

// File: rtl/io_bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the pointer
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);
    // Scan from farthest to nearest so the last hit is the closest to the pointer
    always_comb begin
        o_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (i_req[(int'(i_ptr) + k) % NREQ]) o_idx = PW'((int'(i_ptr) + k) % NREQ);
    end
    assign o_any   = |i_req;
    assign o_grant = o_any ? NREQ'(1) << o_idx : '0;
endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin sharing of the single io_port bus among NREQ masters,
// one transaction in flight with optional wait states.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int WAIT_STATES = 0
) (
    input  logic                      clk,
    input  logic                      resetb,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_we,
    input  logic [NREQ*IO_ADDR_W-1:0] req_addr,
    input  logic [NREQ*IO_DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]           req_ack,
    output logic [IO_DATA_W-1:0]      req_rdata,
    output logic                      busy,
    output logic [IO_ADDR_W-1:0]      io_addr,
    output logic                      io_en,
    output logic                      io_we,
    output logic [IO_DATA_W-1:0]      io_data_write,
    input  logic [IO_DATA_W-1:0]      io_data_read
);
    localparam int PW = $clog2(NREQ);

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic [NREQ-1:0]     r_gnt;
    logic                r_we;
    logic [WAIT_W-1:0]   r_cnt;
    logic [NREQ-1:0]     w_grant;
    logic [PW-1:0]       w_idx;
    logic [PW-1:0]       w_next_ptr;
    logic                w_any;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_next_ptr = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    assign busy       = r_state != ST_IDLE;

    // io_we is registered, so it is raised one cycle ahead of the final ACCESS cycle
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_gnt         <= '0;
            r_we          <= 1'b0;
            r_cnt         <= '0;
            req_ack       <= '0;
            req_rdata     <= '0;
            io_addr       <= '0;
            io_en         <= 1'b0;
            io_we         <= 1'b0;
            io_data_write <= '0;
        end else begin
            req_ack <= '0;
            case (r_state)
                ST_IDLE: if (w_any) begin
                    r_state       <= ST_ACCESS;
                    r_ptr         <= w_next_ptr;
                    r_gnt         <= w_grant;
                    r_we          <= req_we[w_idx];
                    r_cnt         <= WAIT_W'(WAIT_STATES);
                    io_addr       <= req_addr[int'(w_idx)*IO_ADDR_W +: IO_ADDR_W];
                    io_data_write <= req_wdata[int'(w_idx)*IO_DATA_W +: IO_DATA_W];
                    io_en         <= 1'b1;
                    io_we         <= (WAIT_STATES == 0) && req_we[w_idx];
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt - 1'b1;
                    io_we <= (r_cnt == WAIT_W'(1)) && r_we;
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                        io_en   <= 1'b0;
                        io_we   <= 1'b0;
                        req_ack <= r_gnt;
                        if (!r_we) req_rdata <= io_data_read;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: random masters on two arbiter configurations (2 masters/no wait,
// 3 masters/3 wait states) checked cycle by cycle against a transaction-timeline model.
module tb_io_bus_arbiter;
    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  v[2], we[2], ack[2];
    logic [23:0] ad[2];
    logic [95:0] wd[2];
    logic [31:0] rdata[2], iow[2], ior[2];
    logic [7:0]  ioa[2];
    logic        busy[2], en[2], iwe[2];

    int checks = 0;
    int fails = 0;

    function automatic int nr(int g); return (g == 0) ? 2 : 3; endfunction
    function automatic int wt(int g); return (g == 0) ? 0 : 3; endfunction
    function automatic logic [31:0] pat(int a);
        return {a[7:0], ~a[7:0], a[7:0] ^ 8'h5A, 8'hC3};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int N = (g == 0) ? 2 : 3;
        logic [31:0] mem [256];
        io_bus_arbiter #(.NREQ(N), .WAIT_STATES((g == 0) ? 0 : 3)) u_dut (
            .clk           (clk),
            .resetb        (resetb),
            .req_valid     (v[g][N-1:0]),
            .req_we        (we[g][N-1:0]),
            .req_addr      (ad[g][N*8-1:0]),
            .req_wdata     (wd[g][N*32-1:0]),
            .req_ack       (ack[g][N-1:0]),
            .req_rdata     (rdata[g]),
            .busy          (busy[g]),
            .io_addr       (ioa[g]),
            .io_en         (en[g]),
            .io_we         (iwe[g]),
            .io_data_write (iow[g]),
            .io_data_read  (ior[g])
        );
        if (N < 3) begin : g_pad
            assign ack[g][2] = 1'b0;
        end
        // io_port stand-in: combinational read, write on io_we
        assign ior[g] = mem[ioa[g]];
        always @(posedge clk)
            if (!resetb) for (int a = 0; a < 256; a++) mem[a] <= pat(a);
            else if (iwe[g]) mem[ioa[g]] <= iow[g];
    end

    // Model: t = cycles since grant (0 = idle); access cycles 1..W+1, ack at W+2
    int          t[2], ptr[2], win[2], ackd[2], gnt[2];
    logic        twe[2];
    logic [7:0]  taddr[2];
    logic [31:0] twd[2], erd[2];
    logic [31:0] mm[2][256];

    task automatic chk(string tag, int g, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d]: got %h expected %h", tag, g, obs, exp);
        end
    endtask

    task automatic model_reset(int g);
        t[g] = 0; ptr[g] = 0; win[g] = 0; ackd[g] = -1; gnt[g] = -1;
        twe[g] = 1'b0; taddr[g] = '0; twd[g] = '0; erd[g] = '0;
        for (int a = 0; a < 256; a++) mm[g][a] = pat(a);
    endtask

    task automatic check(int g);
        int w = wt(g);
        chk("ack", g, 32'(ack[g] & 3'((1 << nr(g)) - 1)), (t[g] == w + 2) ? 32'(1 << win[g]) : 32'd0);
        chk("busy", g, 32'(busy[g]), 32'(t[g] != 0));
        chk("io_en", g, 32'(en[g]), 32'(t[g] >= 1 && t[g] <= w + 1));
        chk("io_we", g, 32'(iwe[g]), 32'(t[g] == w + 1 && twe[g]));
        chk("io_addr", g, 32'(ioa[g]), 32'(taddr[g]));
        chk("io_data_write", g, iow[g], twd[g]);
        chk("req_rdata", g, rdata[g], erd[g]);
    endtask

    task automatic step(int g);
        int w = wt(g);
        int n = nr(g);
        if (!resetb) model_reset(g);
        else begin
            ackd[g] = (t[g] == w + 2) ? win[g] : -1;
            gnt[g] = -1;
            if (t[g] == 0) begin
                for (int k = 0; k < n; k++) begin
                    int j = (ptr[g] + k) % n;
                    if (v[g][j] && gnt[g] < 0) begin
                        gnt[g] = j; win[g] = j; twe[g] = we[g][j];
                        taddr[g] = ad[g][j*8 +: 8]; twd[g] = wd[g][j*32 +: 32];
                    end
                end
                if (gnt[g] >= 0) begin
                    ptr[g] = (gnt[g] + 1) % n;
                    t[g] = 1;
                end
            end else begin
                if (t[g] == w + 1) begin
                    if (twe[g]) mm[g][taddr[g]] = twd[g];
                    else erd[g] = mm[g][taddr[g]];
                end
                t[g] = (t[g] == w + 2) ? 0 : t[g] + 1;
            end
        end
    endtask

    task automatic new_req(int g, int i);
        v[g][i] = 1'b1;
        we[g][i] = 1'($urandom % 2);
        ad[g][i*8 +: 8] = 8'($urandom % 16);
        wd[g][i*32 +: 32] = $urandom;
    endtask

    // First 60 cycles: every master requests continuously; afterwards random traffic with withdrawals
    task automatic drive(int g, int c);
        for (int i = 0; i < nr(g); i++) begin
            if (!resetb) v[g][i] = 1'b0;
            else if (ackd[g] == i) begin
                if (c < 60 || $urandom % 2 == 0) new_req(g, i);
                else v[g][i] = 1'b0;
            end else if (gnt[g] == i && c >= 60 && $urandom % 3 == 0) v[g][i] = 1'b0;
            else if (!v[g][i] && !(t[g] != 0 && win[g] == i) && (c < 60 || $urandom % 4 == 0))
                new_req(g, i);
        end
    endtask

    initial begin
        int hold = 0;
        bit rst_done = 1'b0;
        for (int g = 0; g < 2; g++) begin
            v[g] = '0; we[g] = '0; ad[g] = '0; wd[g] = '0;
            model_reset(g);
        end
        repeat (2) @(posedge clk);
        #1 resetb = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (hold > 0) begin
                hold--;
                resetb = (hold == 0);
            end else if (!rst_done && c > 200 && t[1] >= 1 && t[1] <= 2 && twe[1]) begin
                resetb = 1'b0;
                hold = 2;
                rst_done = 1'b1;
            end
            for (int g = 0; g < 2; g++) drive(g, c);
            @(negedge clk);
            for (int g = 0; g < 2; g++) check(g);
            for (int g = 0; g < 2; g++) step(g);
            @(posedge clk);
            #1;
        end
        chk("reset_in_write", 1, 32'(rst_done), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
